// File: rtl/sap1_prog_loader.sv
// sap1_prog_loader: streams program words into the SAP-1 program SRAM and holds the CPU in reset
// until the load (and optional readback) completes. Define SAP1_LOADER_VERIFY_EN for checksum readback.
module sap1_prog_loader #(
    parameter int AW       = 5,
    parameter int DW       = 9,
    parameter int DEPTH    = 32,
    parameter int RST_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          cpu_rst,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_VERIFY = 3'd2,
        S_HOLD   = 3'd3,
        S_RUN    = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic [AW:0]   word_count_q, word_count_d;
    logic [3:0]    hold_cnt_q, hold_cnt_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          accept;

`ifdef SAP1_LOADER_VERIFY_EN
    logic          err_q, err_d;
    logic [DW-1:0] csum_q, csum_d;
    logic [DW-1:0] vsum_q, vsum_d;
    logic [AW:0]   vcnt_q, vcnt_d;
    logic [DW-1:0] vsum_next;

    assign vsum_next = vsum_q + mem_rdata;
    assign err       = err_q;
`else
    logic unused_rdata;

    assign unused_rdata = ^mem_rdata;
    assign err          = 1'b0;
`endif

    // last_q marks the write-drain cycle after the final word: no more words are taken,
    // and any readback starts only once that write has landed in the SRAM.
    assign in_ready   = (state_q == S_LOAD) && !last_q;
    assign accept     = in_ready && in_valid;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign word_count = word_count_q;
    assign cpu_rst    = (state_q != S_RUN);
    assign done       = (state_q == S_RUN);
    assign busy       = (state_q != S_IDLE) && (state_q != S_RUN);

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        word_count_d = word_count_q;
        hold_cnt_d   = hold_cnt_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
`ifdef SAP1_LOADER_VERIFY_EN
        err_d        = err_q;
        csum_d       = csum_q;
        vsum_d       = vsum_q;
        vcnt_d       = vcnt_q;
`endif
        case (state_q)
            S_IDLE, S_RUN: begin
                if (start) begin
                    state_d      = S_LOAD;
                    last_d       = 1'b0;
                    word_count_d = '0;
`ifdef SAP1_LOADER_VERIFY_EN
                    err_d        = 1'b0;
                    csum_d       = '0;
`endif
                end
            end
            S_LOAD: begin
                if (accept) begin
                    mem_we_d     = 1'b1;
                    mem_addr_d   = word_count_q[AW-1:0];
                    mem_wdata_d  = in_data;
                    word_count_d = word_count_q + 1'b1;
`ifdef SAP1_LOADER_VERIFY_EN
                    csum_d       = csum_q + in_data;
`endif
                    if (in_last || (word_count_q == (AW+1)'(DEPTH - 1))) begin
                        last_d = 1'b1;
                    end
                end else if (last_q) begin
                    last_d     = 1'b0;
                    hold_cnt_d = '0;
`ifdef SAP1_LOADER_VERIFY_EN
                    state_d    = S_VERIFY;
                    mem_addr_d = '0;
                    vcnt_d     = '0;
                    vsum_d     = '0;
`else
                    state_d    = S_HOLD;
`endif
                end
            end
`ifdef SAP1_LOADER_VERIFY_EN
            // Cycle i presents address i; rdata seen in cycle i belongs to address i-1.
            S_VERIFY: begin
                vcnt_d = vcnt_q + 1'b1;
                if ((vcnt_q + 1'b1) < word_count_q) begin
                    mem_addr_d = mem_addr_q + 1'b1;
                end
                if (vcnt_q != '0) begin
                    vsum_d = vsum_next;
                end
                if (vcnt_q == word_count_q) begin
                    if (vsum_next != csum_q) begin
                        err_d = 1'b1;
                    end
                    state_d    = S_HOLD;
                    hold_cnt_d = '0;
                end
            end
`endif
            S_HOLD: begin
                if (hold_cnt_q == 4'(RST_HOLD - 1)) begin
                    state_d = S_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_q       <= 1'b0;
            word_count_q <= '0;
            hold_cnt_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
`ifdef SAP1_LOADER_VERIFY_EN
            err_q        <= 1'b0;
            csum_q       <= '0;
            vsum_q       <= '0;
            vcnt_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            word_count_q <= word_count_d;
            hold_cnt_q   <= hold_cnt_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
`ifdef SAP1_LOADER_VERIFY_EN
            err_q        <= err_d;
            csum_q       <= csum_d;
            vsum_q       <= vsum_d;
            vcnt_q       <= vcnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_sap1_prog_loader.sv
// Directed bench for sap1_prog_loader with a behavioural 32x9 SRAM (registered read).
module tb_sap1_prog_loader;
    localparam int AW       = 5;
    localparam int DW       = 9;
    localparam int DEPTH    = 32;
    localparam int RST_HOLD = 4;
`ifdef SAP1_LOADER_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          cpu_rst;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   word_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] sram [DEPTH];
    logic          corrupt = 1'b0;
    logic [DW-1:0] prog [4];
    logic [DW-1:0] prog2 [4];

    sap1_prog_loader #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .RST_HOLD(RST_HOLD)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .cpu_rst(cpu_rst), .busy(busy),
        .done(done), .err(err), .word_count(word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) sram[mem_addr] <= mem_wdata;
        mem_rdata <= sram[mem_addr] ^ ((corrupt && mem_addr == 5'd2) ? 9'h001 : 9'h000);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lat(input int wc);
        return RST_HOLD + (VERIFY ? wc + 1 : 0);
    endfunction

    function automatic logic [DW-1:0] pat(input int i);
        return 9'((i * 37 + 5) & 511);
    endfunction

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_ready", 32'(in_ready), 1);
        chk("start_cpu_rst", 32'(cpu_rst), 1);
        chk("start_done", 32'(done), 0);
        chk("start_busy", 32'(busy), 1);
        chk("start_word_count", 32'(word_count), 0);
        chk("start_err", 32'(err), 0);
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic last, input int idx);
        chk("pre_in_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        chk("wr_we", 32'(mem_we), 1);
        chk("wr_addr", 32'(mem_addr), 32'(idx));
        chk("wr_data", 32'(mem_wdata), 32'(d));
        chk("wr_count", 32'(word_count), 32'(idx + 1));
    endtask

    // Called at the negedge of the final write cycle.
    task automatic wait_release(input int l, input bit poke_start);
        for (int k = 1; k <= l; k++) begin
            start = poke_start && (k == 1);
            @(negedge clk);
            start = 1'b0;
            if (k == l) begin
                chk("hold_cpu_rst", 32'(cpu_rst), 1);
                chk("hold_busy", 32'(busy), 1);
            end
        end
        @(negedge clk);
        chk("run_cpu_rst", 32'(cpu_rst), 0);
        chk("run_done", 32'(done), 1);
        chk("run_busy", 32'(busy), 0);
    endtask

    initial begin
        int guard;
        prog[0] = 9'h009; prog[1] = 9'h1EA; prog[2] = 9'h02B; prog[3] = 9'h1E0;
        prog2[0] = 9'h0F1; prog2[1] = 9'h102; prog2[2] = 9'h033; prog2[3] = 9'h1C4;
        rst = 1'b1; start = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cpu_rst", 32'(cpu_rst), 1);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_word_count", 32'(word_count), 0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 0);

        // Load and run, with an ignored start during the drain cycle
        do_start();
        for (int i = 0; i < 4; i++) send_word(prog[i], (i == 3), i);
        chk("drop_in_ready", 32'(in_ready), 0);
        chk("load_count", 32'(word_count), 4);
        wait_release(lat(4), 1'b1);
        for (int i = 0; i < 4; i++) chk("load_sram", 32'(sram[i]), 32'(prog[i]));
        chk("load_err", 32'(err), 0);

        // Full depth: 40 words offered, in_last never set
        do_start();
        for (int i = 0; i < DEPTH; i++) send_word(pat(i), 1'b0, i);
        chk("full_count", 32'(word_count), 32);
        chk("full_in_ready", 32'(in_ready), 0);
        for (int i = DEPTH; i < 40; i++) begin
            in_valid = 1'b1;
            in_data  = pat(i);
            @(negedge clk);
            chk("full_extra_we", 32'(mem_we), 0);
            chk("full_extra_ready", 32'(in_ready), 0);
        end
        in_valid = 1'b0;
        guard = 0;
        while (!done && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("full_done", 32'(done), 1);
        chk("full_count_end", 32'(word_count), 32);
        chk("full_sram0", 32'(sram[0]), 32'(pat(0)));
        chk("full_sram31", 32'(sram[31]), 32'(pat(31)));
        chk("full_err", 32'(err), 0);

        // Reload from RUN with a 3-cycle gap between words 1 and 2
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("reload_cpu_rst", 32'(cpu_rst), 1);
        chk("reload_done", 32'(done), 0);
        chk("reload_count", 32'(word_count), 0);
        send_word(prog[0], 1'b0, 0);
        send_word(prog[1], 1'b0, 1);
        repeat (3) begin
            @(negedge clk);
            chk("gap_we", 32'(mem_we), 0);
            chk("gap_ready", 32'(in_ready), 1);
        end
        send_word(prog[2], 1'b0, 2);
        send_word(prog[3], 1'b1, 3);
        wait_release(lat(4), 1'b0);
        for (int i = 0; i < 4; i++) chk("gap_sram", 32'(sram[i]), 32'(prog[i]));

        // Reset mid-load (with start held in the same cycle), then a clean reload
        do_start();
        send_word(9'h155, 1'b0, 0);
        send_word(9'h0AA, 1'b0, 1);
        in_valid = 1'b1; in_data = 9'h111; rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        chk("mid_rst_ready", 32'(in_ready), 0);
        chk("mid_rst_cpu_rst", 32'(cpu_rst), 1);
        chk("mid_rst_count", 32'(word_count), 0);
        chk("mid_rst_we", 32'(mem_we), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_addr", 32'(mem_addr), 0);
        @(negedge clk);
        do_start();
        for (int i = 0; i < 4; i++) send_word(prog2[i], (i == 3), i);
        wait_release(lat(4), 1'b0);
        for (int i = 0; i < 4; i++) chk("after_rst_sram", 32'(sram[i]), 32'(prog2[i]));

`ifdef SAP1_LOADER_VERIFY_EN
        // Readback corruption at address 2 must flag err yet still release the CPU
        corrupt = 1'b1;
        do_start();
        for (int i = 0; i < 4; i++) send_word(prog[i], (i == 3), i);
        wait_release(lat(4), 1'b0);
        chk("verify_err", 32'(err), 1);
        chk("verify_cpu_rst", 32'(cpu_rst), 0);
        corrupt = 1'b0;
        @(negedge clk);
        chk("verify_err_sticky", 32'(err), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("verify_err_clear", 32'(err), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
